// File: rtl/sync_fifo_ctrl.sv
// Single-clock synchronous FIFO controller.
// Inferred DEPTH x WIDTH dual-port storage, occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// build-time choice of standard or first-word-fall-through read mode.
//
// Handshake: a write is accepted when wr_en is high and the FIFO is not full;
// a read/pop is accepted when rd_en is high and the FIFO is not empty. A
// refused request changes nothing and raises overflow/underflow for exactly
// one cycle afterwards. In standard mode rd_valid marks the cycle in which
// data_out carries freshly read data; in FWFT mode rd_valid == !empty and
// data_out shows the head entry.
module sync_fifo_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Pointer width; DEPTH need not be a power of two, so wrap is explicit.
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come only from the registered count, never from pointer compares.
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_empty = (int'(count) <= AE_LEVEL);
  assign almost_full  = (int'(count) >= AF_LEVEL);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage write; not reset, and suppressed during the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Error pulses: one cycle after a request refused by full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; zero while nothing is stored.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      // Registered read port: data appears the cycle after an accepted read
      // and otherwise holds its last value.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) begin
            data_q <= mem[rd_ptr];
          end
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-mode DEPTH=16 instance and a FWFT
// DEPTH=5 instance, each followed by a queue-based reference model that is
// compared against the outputs every cycle, plus directed literal checks.
module tb_sync_fifo_ctrl;

  localparam int S_DEPTH = 16;
  localparam int S_AF    = 14;
  localparam int S_AE    = 2;
  localparam int F_DEPTH = 5;
  localparam int F_AF    = 4;
  localparam int F_AE    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        s_wr = 1'b0, s_rd = 1'b0;
  logic [31:0] s_din = '0, s_dout;
  logic        s_rv, s_empty, s_full, s_ae, s_af, s_ov, s_un;
  logic [4:0]  s_count;

  logic        f_wr = 1'b0, f_rd = 1'b0;
  logic [31:0] f_din = '0, f_dout;
  logic        f_rv, f_empty, f_full, f_ae, f_af, f_ov, f_un;
  logic [2:0]  f_count;

  sync_fifo_ctrl #(
    .WIDTH(32), .DEPTH(S_DEPTH), .FWFT(0), .AF_LEVEL(S_AF), .AE_LEVEL(S_AE)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
    .data_out(s_dout), .rd_valid(s_rv), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_ctrl #(
    .WIDTH(32), .DEPTH(F_DEPTH), .FWFT(1), .AF_LEVEL(F_AF), .AE_LEVEL(F_AE)
  ) u_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
    .data_out(f_dout), .rd_valid(f_rv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ov), .underflow(f_un)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference models ----------------
  logic [31:0] s_q[$];
  logic [31:0] f_q[$];
  logic [31:0] s_exp_dout = '0;
  logic        s_exp_rv = 1'b0, s_exp_ov = 1'b0, s_exp_un = 1'b0;
  logic        f_exp_ov = 1'b0, f_exp_un = 1'b0;
  logic        started = 1'b0;

  // Advance both models with the inputs presented at this edge.
  always @(posedge clk) begin
    if (rst) begin
      s_q.delete();
      f_q.delete();
      s_exp_dout = '0;
      s_exp_rv   = 1'b0;
      s_exp_ov   = 1'b0;
      s_exp_un   = 1'b0;
      f_exp_ov   = 1'b0;
      f_exp_un   = 1'b0;
      started    = 1'b1;
    end else begin
      // standard-mode instance
      s_exp_ov = s_wr && (s_q.size() == S_DEPTH);
      s_exp_un = s_rd && (s_q.size() == 0);
      s_exp_rv = s_rd && (s_q.size() != 0);
      begin
        logic do_w;
        do_w = s_wr && (s_q.size() != S_DEPTH);
        if (s_exp_rv) s_exp_dout = s_q.pop_front();
        if (do_w) s_q.push_back(s_din);
      end
      // FWFT instance
      f_exp_ov = f_wr && (f_q.size() == F_DEPTH);
      f_exp_un = f_rd && (f_q.size() == 0);
      begin
        logic do_w, do_r;
        do_w = f_wr && (f_q.size() != F_DEPTH);
        do_r = f_rd && (f_q.size() != 0);
        if (do_r) void'(f_q.pop_front());
        if (do_w) f_q.push_back(f_din);
      end
    end
  end

  // Compare every output against the models on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("s_count", 32'(s_count), s_q.size());
      chk("s_empty", 32'(s_empty), 32'(s_q.size() == 0));
      chk("s_full", 32'(s_full), 32'(s_q.size() == S_DEPTH));
      chk("s_ae", 32'(s_ae), 32'(s_q.size() <= S_AE));
      chk("s_af", 32'(s_af), 32'(s_q.size() >= S_AF));
      chk("s_ov", 32'(s_ov), 32'(s_exp_ov));
      chk("s_un", 32'(s_un), 32'(s_exp_un));
      chk("s_rv", 32'(s_rv), 32'(s_exp_rv));
      chk("s_dout", s_dout, s_exp_dout);
      chk("f_count", 32'(f_count), f_q.size());
      chk("f_empty", 32'(f_empty), 32'(f_q.size() == 0));
      chk("f_full", 32'(f_full), 32'(f_q.size() == F_DEPTH));
      chk("f_ae", 32'(f_ae), 32'(f_q.size() <= F_AE));
      chk("f_af", 32'(f_af), 32'(f_q.size() >= F_AF));
      chk("f_ov", 32'(f_ov), 32'(f_exp_ov));
      chk("f_un", 32'(f_un), 32'(f_exp_un));
      chk("f_rv", 32'(f_rv), 32'(f_q.size() != 0));
      if (f_q.size() != 0) chk("f_dout", f_dout, f_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  // Present inputs, let one rising edge consume them, return 1 ns after it.
  task automatic drive(input logic r, input logic sw, input logic sr, input logic [31:0] sd,
                       input logic fw, input logic fr, input logic [31:0] fd);
    rst   = r;
    s_wr  = sw;
    s_rd  = sr;
    s_din = sd;
    f_wr  = fw;
    f_rd  = fr;
    f_din = fd;
    @(posedge clk);
    #1;
  endtask

  task automatic std_op(input logic w, input logic r, input logic [31:0] d);
    drive(1'b0, w, r, d, 1'b0, 1'b0, '0);
  endtask

  task automatic fw_op(input logic w, input logic r, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b0, '0, w, r, d);
  endtask

  task automatic chk_std_reset(input string tag);
    chk({tag, "_count"}, 32'(s_count), 0);
    chk({tag, "_empty"}, 32'(s_empty), 1);
    chk({tag, "_full"}, 32'(s_full), 0);
    chk({tag, "_dout"}, s_dout, 0);
    chk({tag, "_rv"}, 32'(s_rv), 0);
    chk({tag, "_ae"}, 32'(s_ae), 1);
    chk({tag, "_af"}, 32'(s_af), 0);
    chk({tag, "_ov"}, 32'(s_ov), 0);
    chk({tag, "_un"}, 32'(s_un), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_std_reset("rst");
    std_op(1'b0, 1'b0, '0);
    chk_std_reset("idle");

    // Fill 0x1..0x10; watch almost_empty/almost_full thresholds.
    for (int i = 1; i <= 16; i++) begin
      std_op(1'b1, 1'b0, 32'(i));
      if (i == 2)  chk("fill_ae_at2", 32'(s_ae), 1);
      if (i == 3)  chk("fill_ae_at3", 32'(s_ae), 0);
      if (i == 13) chk("fill_af_at13", 32'(s_af), 0);
      if (i == 14) chk("fill_af_at14", 32'(s_af), 1);
    end
    chk("fill_count", 32'(s_count), 16);
    chk("fill_full", 32'(s_full), 1);
    std_op(1'b1, 1'b0, 32'h11);
    chk("ovf_pulse", 32'(s_ov), 1);
    chk("ovf_count", 32'(s_count), 16);
    std_op(1'b0, 1'b0, '0);
    chk("ovf_clear", 32'(s_ov), 0);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      std_op(1'b0, 1'b1, '0);
      chk("drain_data", s_dout, 32'(i));
      chk("drain_rv", 32'(s_rv), 1);
    end
    chk("drain_empty", 32'(s_empty), 1);
    std_op(1'b0, 1'b0, '0);
    chk("hold_rv", 32'(s_rv), 0);
    chk("hold_dout", s_dout, 32'h10);

    // Count 5, then 40 cycles of simultaneous write+read across the wrap.
    for (int i = 1; i <= 5; i++) std_op(1'b1, 1'b0, 32'h100 + 32'(i));
    for (int k = 0; k < 40; k++) begin
      std_op(1'b1, 1'b1, 32'h200 + 32'(k));
      chk("wr_rd_count", 32'(s_count), 5);
      chk("wr_rd_data", s_dout, (k < 5) ? 32'h101 + 32'(k) : 32'h200 + 32'(k - 5));
    end
    for (int i = 0; i < 5; i++) std_op(1'b0, 1'b1, '0);
    chk("wr_rd_empty", 32'(s_empty), 1);

    // Empty: write accepted, read refused.
    std_op(1'b1, 1'b1, 32'h55);
    chk("empty_wr_rd_un", 32'(s_un), 1);
    chk("empty_wr_rd_count", 32'(s_count), 1);
    chk("empty_wr_rd_rv", 32'(s_rv), 0);
    for (int i = 0; i < 15; i++) std_op(1'b1, 1'b0, 32'h60 + 32'(i));
    // Full: read accepted, write refused.
    std_op(1'b1, 1'b1, 32'h66);
    chk("full_wr_rd_ov", 32'(s_ov), 1);
    chk("full_wr_rd_count", 32'(s_count), 15);
    chk("full_wr_rd_dout", s_dout, 32'h55);
    std_op(1'b1, 1'b0, 32'h67);
    chk("refill_count", 32'(s_count), 16);

    // Reset at count 9, with requests in the reset cycle.
    for (int i = 0; i < 7; i++) std_op(1'b0, 1'b1, '0);
    chk("pre_rst_count", 32'(s_count), 9);
    drive(1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, '0);
    chk_std_reset("midrst");
    std_op(1'b0, 1'b0, '0);
    chk_std_reset("postrst");

    // FWFT: first write visible one cycle later.
    fw_op(1'b1, 1'b0, 32'hA5);
    chk("fw_first_dout", f_dout, 32'hA5);
    chk("fw_first_rv", 32'(f_rv), 1);
    fw_op(1'b0, 1'b1, '0);
    chk("fw_pop_empty", 32'(f_empty), 1);
    chk("fw_pop_rv", 32'(f_rv), 0);
    fw_op(1'b0, 1'b1, '0);
    chk("fw_un_pulse", 32'(f_un), 1);
    fw_op(1'b0, 1'b0, '0);
    chk("fw_un_clear", 32'(f_un), 0);

    // FWFT DEPTH=5: three fill/drain rounds starting mid-array.
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 5; j++) fw_op(1'b1, 1'b0, 32'(c * 16 + j + 1));
      chk("fw_full", 32'(f_full), 1);
      chk("fw_full_count", 32'(f_count), 5);
      if (c == 0) begin
        fw_op(1'b1, 1'b0, 32'hEE);
        chk("fw_ov_pulse", 32'(f_ov), 1);
        chk("fw_ov_count", 32'(f_count), 5);
      end
      for (int j = 0; j < 5; j++) begin
        chk("fw_head", f_dout, 32'(c * 16 + j + 1));
        chk("fw_head_rv", 32'(f_rv), 1);
        fw_op(1'b0, 1'b1, '0);
      end
      chk("fw_drained", 32'(f_empty), 1);
    end

    fw_op(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
